fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage RV32I pipeline; sits directly upstream of decode.
- Owns the fetch PC and drives a request/grant/response instruction-memory port with one outstanding request.
- Owns the IF/ID pipeline register that supplies decode's instrD, pcD and pc4D, and applies stall, flush and execute-stage redirects.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID when empty or flushed.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- stallD  in  1  hazard unit: hold IF/ID contents.
- flushD  in  1  hazard unit: kill IF/ID contents.
- pcselE  in  1  execute stage: taken branch or jump; redirect fetch.
- targetE  in  32  redirect target address from execute.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; always equals pcF.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  instruction data valid.
- imem_rdata  in  32  instruction word.
- instrD  out  32  IF/ID instruction.
- pcD  out  32  IF/ID PC.
- pc4D  out  32  IF/ID PC+4.
- validD  out  1  IF/ID holds a real instruction.
- pcF  out  32  next address to request (debug).

Behaviour:
- Reset (synchronous, rst=1): pcF=RESET_PC, state=REQ, instrD=NOP_INSTR, pcD=0, pc4D=0, validD=0, req_pc=0, hold buffer cleared.
- Internal registers: pcF (next address to issue), req_pc (address of the outstanding request), hold_instr/hold_pc, state.
- States:
  - REQ: imem_req=1.
  - WAIT: one request outstanding.
  - HOLD: response captured while stallD=1.
  - DROP: outstanding response is to be discarded.
- Grant (imem_req && imem_gnt): req_pc<=pcF; pcF<=pcF+4; next state WAIT.
- REQ: without a grant, stay in REQ. imem_rvalid is ignored in REQ, so stale data after reset is discarded.
- WAIT, imem_rvalid=1 and stallD=0:
  - Load IF/ID: instrD=imem_rdata, pcD=req_pc, pc4D=req_pc+4, validD=1.
  - imem_req=1 in the same cycle (back-to-back issue).
  - If granted, stay in WAIT; otherwise go to REQ.
- WAIT, imem_rvalid=1 and stallD=1: capture rdata and req_pc into the hold buffer, go to HOLD, imem_req=0.
- WAIT, imem_rvalid=0: imem_req=0, stay in WAIT.
- HOLD: imem_req=0. When stallD=0, load IF/ID from the hold buffer (validD=1) and go to REQ.
- DROP: imem_req=0. On imem_rvalid, discard the data and go to REQ.
- Redirect (pcselE=1) has highest priority over every state action:
  - pcF<=targetE, overriding the +4 increment.
  - Any grant in the same cycle, or a pending request in WAIT, goes to DROP.
  - A response arriving in the same cycle is discarded.
  - HOLD contents are discarded and the state becomes REQ.
  - A redirect in DROP updates pcF and stays in DROP.
  - The IF/ID register is not written from memory in a redirect cycle.
- flushD=1: instrD=NOP_INSTR, pcD=0, pc4D=0, validD=0. flushD beats stallD. flushD does not affect pcF or state.
- stallD=1 without flushD: IF/ID holds its value.
- Arithmetic: all address math is 32-bit modulo 2^32; 0xFFFF_FFFC+4 wraps to 0. Low two address bits pass through unchanged.
- Throughput:
  - Memory that grants in the same cycle and returns rvalid the next cycle gives 1 instruction per cycle after a 2-cycle initial latency (request cycle plus response cycle).
  - Each redirect costs at least 1 bubble.
- Reset asserted mid-operation (any state) returns to the reset values on the next edge. The memory must drop outstanding requests on the same rst.

Optional Feature:
- Macro FETCH_PERF_EN. When defined, the block adds two outputs:
  - perf_fetched [31:0]: increments on every IF/ID load with validD=1.
  - perf_bubbles [31:0]: increments every cycle where stallD=0 and IF/ID is loaded with a bubble or left empty.
  - Both counters are cleared by rst and wrap at 2^32.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0x0 -> first cycle imem_req=1, imem_addr=0x0, instrD=0x00000013, validD=0.
- Zero-wait memory (gnt=1, rvalid the next cycle) serving 0x0/0x4/0x8 -> instrD updates every cycle; pcD sequence 0x0,0x4,0x8; pc4D 0x4,0x8,0xC; validD=1.
- stallD held 3 cycles as the response for 0x4 arrives -> IF/ID keeps 0x0, state HOLD, no imem_req. On release, 0x4 is delivered exactly once and the next request is 0x8.
- pcselE=1, targetE=0x100 while WAIT for 0x8 -> the late 0x8 response is dropped, the next imem_addr is 0x100, and the next pcD is 0x100.
- flushD=1 and stallD=1 together -> instrD=0x00000013, validD=0, pcD=0.
- rst pulsed during WAIT, then rvalid arrives -> response ignored, imem_addr=RESET_PC. With FETCH_PERF_EN, perf_fetched=0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/grant/response port for the fetch stage.
// One outstanding request at a time; the memory returns rvalid/rdata
// some cycles after a granted request.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the fetch PC, the single-outstanding
// instruction-memory port and the IF/ID pipeline register.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_bubbles.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcselE,
  input  logic [31:0] targetE,
  fetch_stage_if.master imem,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pc4D,
  output logic        validD,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles,
`endif
  output logic [31:0] pcF
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state;
  logic [31:0] req_pc;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;

  logic        resp_ok;
  logic        req;
  logic        grant;
  logic        load_mem;
  logic        load_hold;
  logic        load;
  logic [31:0] load_instr;
  logic [31:0] load_pc;

  // Request is combinational so a response can trigger the next issue in
  // the same cycle (back-to-back fetch at one instruction per cycle).
  always_comb begin
    resp_ok    = (state == S_WAIT) && imem.rvalid;
    req        = (state == S_REQ) || (resp_ok && !stallD);
    grant      = req && imem.gnt;
    load_mem   = resp_ok && !stallD && !pcselE;
    load_hold  = (state == S_HOLD) && !stallD && !pcselE;
    load       = load_mem || load_hold;
    load_instr = load_hold ? hold_instr : imem.rdata;
    load_pc    = load_hold ? hold_pc    : req_pc;
  end

  assign imem.req  = req;
  assign imem.addr = pcF;

  // Fetch PC, outstanding-request bookkeeping, hold buffer and FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pcF        <= RESET_PC;
      req_pc     <= 32'h0;
      hold_instr <= 32'h0;
      hold_pc    <= 32'h0;
    end else begin
      if (grant) req_pc <= pcF;

      if (pcselE)     pcF <= targetE;
      else if (grant) pcF <= pcF + 32'd4;

      if (resp_ok && stallD && !pcselE) begin
        hold_instr <= imem.rdata;
        hold_pc    <= req_pc;
      end

      if (pcselE) begin
        // Anything still in flight after this edge belongs to the old path.
        if (grant || ((state == S_WAIT || state == S_DROP) && !imem.rvalid))
          state <= S_DROP;
        else
          state <= S_REQ;
      end else begin
        case (state)
          S_REQ:  state <= grant ? S_WAIT : S_REQ;
          S_WAIT: begin
            if (imem.rvalid) begin
              if (stallD)     state <= S_HOLD;
              else if (grant) state <= S_WAIT;
              else            state <= S_REQ;
            end
          end
          S_HOLD: if (!stallD)     state <= S_REQ;
          S_DROP: if (imem.rvalid) state <= S_REQ;
          default: state <= S_REQ;
        endcase
      end
    end
  end

  // IF/ID register: flush beats stall; an unstalled cycle with nothing to
  // deliver inserts a bubble so decode never sees an instruction twice.
  always_ff @(posedge clk) begin
    if (rst || flushD) begin
      instrD <= NOP_INSTR;
      pcD    <= 32'h0;
      pc4D   <= 32'h0;
      validD <= 1'b0;
    end else if (!stallD) begin
      if (load) begin
        instrD <= load_instr;
        pcD    <= load_pc;
        pc4D   <= load_pc + 32'd4;
        validD <= 1'b1;
      end else begin
        instrD <= NOP_INSTR;
        pcD    <= 32'h0;
        pc4D   <= 32'h0;
        validD <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Delivered-instruction and bubble counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'h0;
      perf_bubbles <= 32'h0;
    end else if (!stallD) begin
      if (load && !flushD) perf_fetched <= perf_fetched + 32'd1;
      else                 perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic, all
// checked against a transaction-level model of in-flight / held fetches.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallD = 1'b0, flushD = 1'b0, pcselE = 1'b0;
  logic [31:0] targetE = 32'h0;
  logic [31:0] instrD, pcD, pc4D, pcF;
  logic        validD;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  fetch_stage_if imem();

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stallD(stallD), .flushD(flushD),
    .pcselE(pcselE), .targetE(targetE), .imem(imem),
    .instrD(instrD), .pcD(pcD), .pc4D(pc4D), .validD(validD),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles),
`endif
    .pcF(pcF)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: fetch PC, in-flight request, held response, expected IF/ID
  logic [31:0] m_pc, m_inf_pc, m_held_pc, m_held_w;
  logic        m_inf, m_kill, m_held;
  logic [31:0] m_instr, m_pcD, m_pc4D;
  logic        m_valid;
  logic [31:0] m_fetched, m_bubbles;
  // memory side
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'h0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_inf = 0; m_kill = 0; m_inf_pc = 0;
    m_held = 0; m_held_pc = 0; m_held_w = 0;
    m_instr = NOP; m_pcD = 0; m_pc4D = 0; m_valid = 0;
    m_fetched = 0; m_bubbles = 0;
  endtask

  // One clock cycle. rvm: 0 no rvalid, 1 rvalid if memory has a request, 2 forced.
  task automatic step(input bit r, input bit st, input bit fl, input bit ps,
                      input logic [31:0] tg, input bit g, input int rvm);
    logic        er, rvv, mgrant, dgrant, resp, deliver;
    logic [31:0] rin, aout, dw, dpc;
    rst = r; stallD = st; flushD = fl; pcselE = ps; targetE = tg;
    rvv = (rvm == 2) || (rvm == 1 && mem_pend);
    rin = word(mem_addr);
    imem.rvalid = rvv; imem.rdata = rin; imem.gnt = g;
    #1;
    er = (!m_inf && !m_held) || (m_inf && !m_kill && rvv && !st);
    if (!r) begin
      chk("imem_req", imem.req, er);
      chk("imem_addr", imem.addr, m_pc);
    end
    dgrant = imem.req && g;
    aout   = imem.addr;
    mgrant = er && g;
    @(posedge clk);
    if (r) mem_pend = 0;
    else begin
      if (rvv) mem_pend = 0;
      if (dgrant) begin mem_pend = 1; mem_addr = aout; end
    end
    if (r) model_reset();
    else begin
      resp = m_inf && rvv;
      deliver = 0; dw = 0; dpc = 0;
      if (ps) m_held = 0;
      else if (resp && !m_kill) begin
        if (!st) begin deliver = 1; dw = rin; dpc = m_inf_pc; end
        else begin m_held = 1; m_held_w = rin; m_held_pc = m_inf_pc; end
      end else if (m_held && !st) begin
        deliver = 1; dw = m_held_w; dpc = m_held_pc; m_held = 0;
      end
      if (resp) m_inf = 0;
      else if (ps && m_inf) m_kill = 1;
      if (mgrant) begin m_inf = 1; m_inf_pc = m_pc; m_kill = ps; end
      m_pc = ps ? tg : (mgrant ? m_pc + 32'd4 : m_pc);
      if (fl || (!st && !deliver)) begin
        m_instr = NOP; m_pcD = 0; m_pc4D = 0; m_valid = 0;
      end else if (!st) begin
        m_instr = dw; m_pcD = dpc; m_pc4D = dpc + 32'd4; m_valid = 1;
      end
      if (!st) begin
        if (deliver && !fl) m_fetched = m_fetched + 1;
        else                m_bubbles = m_bubbles + 1;
      end
    end
    #1;
    chk("instrD", instrD, m_instr);
    chk("pcD", pcD, m_pcD);
    chk("pc4D", pc4D, m_pc4D);
    chk("validD", validD, m_valid);
    chk("pcF", pcF, m_pc);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_bubbles", perf_bubbles, m_bubbles);
`endif
  endtask

  initial begin
    imem.gnt = 0; imem.rvalid = 0; imem.rdata = 0;
    model_reset();
    // reset
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_instrD", instrD, NOP);
    chk("rst_validD", validD, 1'b0);
    // zero-wait memory: request 0, then 0x0 delivered while 0x4 issues
    step(0, 0, 0, 0, 0, 1, 1);
    chk("lat_validD", validD, 1'b0);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("zw_pcD0", pcD, 32'h0);
    chk("zw_pc4D0", pc4D, 32'h4);
    // stall as 0x4 response arrives, held 3 cycles
    step(0, 1, 0, 0, 0, 1, 1);
    chk("stall_req", imem.req, 1'b0);
    step(0, 1, 0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0, 1, 1);
    chk("stall_pcD", pcD, 32'h0);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("release_pcD", pcD, 32'h4);
    chk("release_instr", instrD, word(32'h4));
    step(0, 0, 0, 0, 0, 1, 1);          // issues 0x8
    chk("after_hold_pcD", pcD, 32'h0);
    // redirect while waiting on 0x8
    step(0, 0, 0, 1, 32'h100, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);          // late 0x8 dropped
    chk("drop_valid", validD, 1'b0);
    chk("redir_addr", imem.addr, 32'h100);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("redir_pcD", pcD, 32'h100);
    // flush and stall together
    step(0, 1, 1, 0, 0, 1, 1);
    chk("flush_instr", instrD, NOP);
    chk("flush_valid", validD, 1'b0);
    chk("flush_pcD", pcD, 32'h0);
    // redirect out of HOLD to the top of memory, then wrap
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("wrap_pcD", pcD, 32'hFFFF_FFFC);
    chk("wrap_pc4D", pc4D, 32'h0);
    chk("wrap_addr", imem.addr, 32'h4);
    // reset while waiting, then a stale rvalid
    step(1, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 2);
    chk("stale_valid", validD, 1'b0);
    chk("stale_addr", imem.addr, RST_PC);
`ifdef FETCH_PERF_EN
    chk("stale_perf", perf_fetched, 32'h0);
`endif
    // random traffic
    for (int i = 0; i < 500; i++) begin
      logic [31:0] tg;
      tg = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 | 32'($urandom_range(0, 7))
                                       : $urandom;
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 10,
           tg,
           $urandom_range(0, 99) < 70,
           ($urandom_range(0, 99) < 60) ? 1 : (($urandom_range(0, 99) < 5) ? 2 : 0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
